// File: rtl/dmem_sync.sv
// Synchronous-read data memory: hardware clear sequencer, write-protected low region, RD_LAT 1/2 read pipeline.
// Optional DMEM_PARITY_EN adds a stored even-parity bit per word and a par_err flag qualified by rvalid.
module dmem_sync #(
  parameter  int WORD_W   = 8,
  parameter  int OP_W     = 3,
  parameter  int RD_LAT   = 1,
  parameter  int RO_LIMIT = 0,
  localparam int ADDR_W   = WORD_W - OP_W,
  localparam int DEPTH    = 2 ** ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              clr,
  input  logic              par_inj,
  output logic              ready,
  output logic              rvalid,
  output logic [WORD_W-1:0] rdata,
  output logic              wr_err,
  output logic              init_done,
  output logic              par_err
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              init_reg, init_next;
  logic              accept, rd_accept, wr_accept, prot;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_q_reg;
  logic              v1_reg, wr_err_reg;

  assign ready     = (state_reg == IDLE);
  assign init_done = init_reg;
  assign wr_err    = wr_err_reg;
  // A clr request in IDLE takes priority over a req presented in the same cycle.
  assign accept    = req && ready && !clr && !reset;
  assign rd_accept = accept && !we;
  assign wr_accept = accept && we;

  if (RO_LIMIT == 0) begin : g_noprot
    assign prot = 1'b0;
  end else begin : g_prot
    assign prot = ({{(32-ADDR_W){1'b0}}, addr} < 32'(RO_LIMIT));
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_next  = init_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
          state_next = IDLE;
          init_next  = 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      init_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      init_reg  <= init_next;
    end
  end

  // Single write port shared by the clear sequencer and accepted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (!reset) begin
      if (state_reg == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
      end else if (wr_accept && !prot) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_q_reg  <= '0;
      v1_reg     <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      if (rd_accept) ram_q_reg <= mem[addr];
      v1_reg     <= rd_accept;
      wr_err_reg <= wr_accept && prot;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign rvalid = v1_reg;
    assign rdata  = ram_q_reg;
  end else begin : g_lat2
    logic              v2_reg;
    logic [WORD_W-1:0] rdata_reg;
    always_ff @(posedge clock) begin
      if (reset) begin
        v2_reg    <= 1'b0;
        rdata_reg <= '0;
      end else begin
        v2_reg <= v1_reg;
        if (v1_reg) rdata_reg <= ram_q_reg;
      end
    end
    assign rvalid = v2_reg;
    assign rdata  = rdata_reg;
  end

`ifdef DMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_q_reg, out_par, par_wbit;

  assign par_wbit = (state_reg == CLEAR) ? 1'b0 : ((^wdata) ^ par_inj);

  always_ff @(posedge clock) begin
    if (mem_we) par_mem[mem_waddr] <= par_wbit;
  end

  always_ff @(posedge clock) begin
    if (reset)          par_q_reg <= 1'b0;
    else if (rd_accept) par_q_reg <= par_mem[addr];
  end

  if (RD_LAT == 1) begin : g_par1
    assign out_par = par_q_reg;
  end else begin : g_par2
    logic par_d_reg;
    always_ff @(posedge clock) begin
      if (reset)       par_d_reg <= 1'b0;
      else if (v1_reg) par_d_reg <= par_q_reg;
    end
    assign out_par = par_d_reg;
  end

  assign par_err = rvalid && ((^rdata) != out_par);
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign par_err        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_sync.sv
// Bench for dmem_sync: two instances (RD_LAT=1/no protection, RD_LAT=2/RO_LIMIT=4) share stimulus and are checked against a memory-array model.
module tb_dmem_sync;
  localparam int DEPTH = 32;
`ifdef DMEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, req, we, clr, par_inj;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       ready_s [2];
  logic       rvalid_s [2];
  logic       wr_err_s [2];
  logic       init_s [2];
  logic       perr_s [2];
  logic [7:0] rdata_s [2];

  always #5 clock = ~clock;

  dmem_sync #(.WORD_W(8), .OP_W(3), .RD_LAT(1), .RO_LIMIT(0)) u_dut0 (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .clr(clr), .par_inj(par_inj), .ready(ready_s[0]), .rvalid(rvalid_s[0]),
    .rdata(rdata_s[0]), .wr_err(wr_err_s[0]), .init_done(init_s[0]), .par_err(perr_s[0]));

  dmem_sync #(.WORD_W(8), .OP_W(3), .RD_LAT(2), .RO_LIMIT(4)) u_dut1 (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .clr(clr), .par_inj(par_inj), .ready(ready_s[1]), .rvalid(rvalid_s[1]),
    .rdata(rdata_s[1]), .wr_err(wr_err_s[1]), .init_done(init_s[1]), .par_err(perr_s[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int ro_of(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  typedef struct {
    int         dut;
    int         due;
    logic [7:0] data;
    logic       perr;
  } rd_t;

  // Model state: edge count, clear words remaining, memory contents per instance, outstanding reads.
  int         cyc = 0;
  int         clear_left = DEPTH;
  bit         m_init = 1'b0;
  logic [7:0] m_mem [2][DEPTH];
  bit         m_inj [2][DEPTH];
  logic [7:0] m_last [2];
  bit         m_werr [2];
  rd_t        rq [$];
  bit         checking = 1'b0;
  int         nvec = 0;
  int         nfail = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s dut%0d cyc %0d: got %0h want %0h", nm, d, cyc, got, want);
    end
  endtask

  always @(posedge clock) begin : model
    rd_t e;
    cyc = cyc + 1;
    if (reset) begin
      clear_left = DEPTH;
      m_init     = 1'b0;
      rq.delete();
      for (int d = 0; d < 2; d++) begin
        m_last[d] = 8'h00;
        m_werr[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) m_werr[d] = 1'b0;
      if (clear_left > 0) begin
        for (int d = 0; d < 2; d++) begin
          m_mem[d][DEPTH-clear_left] = 8'h00;
          m_inj[d][DEPTH-clear_left] = 1'b0;
        end
        clear_left = clear_left - 1;
        if (clear_left == 0) m_init = 1'b1;
      end else if (clr) begin
        clear_left = DEPTH;
      end else if (req) begin
        for (int d = 0; d < 2; d++) begin
          if (we) begin
            if (int'(addr) < ro_of(d)) m_werr[d] = 1'b1;
            else begin
              m_mem[d][addr] = wdata;
              m_inj[d][addr] = par_inj;
            end
          end else begin
            e.dut  = d;
            e.due  = cyc + lat_of(d) - 1;
            e.data = m_mem[d][addr];
            e.perr = PAR_ON && m_inj[d][addr];
            rq.push_back(e);
          end
        end
      end
    end
  end

  always @(negedge clock) begin : compare
    bit         found;
    logic [7:0] exp_data;
    logic       exp_perr;
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        found    = 1'b0;
        exp_data = 8'h00;
        exp_perr = 1'b0;
        for (int i = 0; i < rq.size(); i++) begin
          if (rq[i].dut == d && rq[i].due == cyc) begin
            found    = 1'b1;
            exp_data = rq[i].data;
            exp_perr = rq[i].perr;
            rq.delete(i);
            break;
          end
        end
        if (found) m_last[d] = exp_data;
        chk("ready", d, 32'(ready_s[d]), 32'(clear_left == 0));
        chk("rvalid", d, 32'(rvalid_s[d]), 32'(found));
        chk("rdata", d, 32'(rdata_s[d]), 32'(m_last[d]));
        chk("wr_err", d, 32'(wr_err_s[d]), 32'(m_werr[d]));
        chk("init_done", d, 32'(init_s[d]), 32'(m_init));
        chk("par_err", d, 32'(perr_s[d]), 32'(found && exp_perr));
      end
    end
  end

  task automatic cycle(input logic r, input logic w, input logic [4:0] a,
                       input logic [7:0] dd, input logic c, input logic inj);
    req = r; we = w; addr = a; wdata = dd; clr = c; par_inj = inj;
    @(posedge clock);
    #1;
    req = 1'b0; clr = 1'b0; par_inj = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] dd, input logic inj);
    cycle(1'b1, 1'b1, a, dd, 1'b0, inj);
  endtask

  task automatic rd(input logic [4:0] a);
    cycle(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0);
  endtask

  // Single read with literal expectations for both latencies.
  task automatic read_lit(input logic [4:0] a, input logic [7:0] w0, input logic [7:0] w1);
    rd(a);
    chk("lit_rvalid_lat1", 0, 32'(rvalid_s[0]), 32'd1);
    chk("lit_rdata_lat1", 0, 32'(rdata_s[0]), 32'(w0));
    chk("lit_no_rvalid_yet", 1, 32'(rvalid_s[1]), 32'd0);
    idle();
    chk("lit_rvalid_lat2", 1, 32'(rvalid_s[1]), 32'd1);
    chk("lit_rdata_lat2", 1, 32'(rdata_s[1]), 32'(w1));
  endtask

  initial begin
    int r;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 8'h00; clr = 1'b0; par_inj = 1'b0;
    @(posedge clock);
    #1;
    checking = 1'b1;
    chk("lit_reset_ready", 0, 32'(ready_s[0]), 32'd0);
    chk("lit_reset_rdata", 1, 32'(rdata_s[1]), 32'd0);
    reset = 1'b0;

    // Initial clear: 32 edges with ready low
    for (int i = 0; i < DEPTH; i++) begin
      chk("lit_ready_during_clear", 0, 32'(ready_s[0]), 32'd0);
      idle();
    end
    chk("lit_ready_after_clear", 0, 32'(ready_s[0]), 32'd1);
    chk("lit_init_done", 1, 32'(init_s[1]), 32'd1);
    read_lit(5'd0, 8'h00, 8'h00);
    read_lit(5'd17, 8'h00, 8'h00);
    read_lit(5'd31, 8'h00, 8'h00);

    // Read immediately after write
    wr(5'd5, 8'hA5, 1'b0);
    read_lit(5'd5, 8'hA5, 8'hA5);

    // Back-to-back reads come back in order
    wr(5'd1, 8'h11, 1'b0);
    wr(5'd2, 8'h22, 1'b0);
    wr(5'd3, 8'h33, 1'b0);
    rd(5'd1);
    chk("lit_b2b_0", 0, 32'(rdata_s[0]), 32'h11);
    rd(5'd2);
    chk("lit_b2b_1", 0, 32'(rdata_s[0]), 32'h22);
    rd(5'd3);
    chk("lit_b2b_2", 0, 32'(rdata_s[0]), 32'h33);
    chk("lit_b2b_valid", 0, 32'(rvalid_s[0]), 32'd1);
    idle();
    idle();

    // Write protection below address 4 on the second instance
    wr(5'd3, 8'hFF, 1'b0);
    chk("lit_wr_err_prot", 1, 32'(wr_err_s[1]), 32'd1);
    chk("lit_wr_err_open", 0, 32'(wr_err_s[0]), 32'd0);
    idle();
    chk("lit_wr_err_pulse", 1, 32'(wr_err_s[1]), 32'd0);
    read_lit(5'd3, 8'hFF, 8'h00);
    wr(5'd4, 8'hFF, 1'b0);
    chk("lit_wr_err_boundary", 1, 32'(wr_err_s[1]), 32'd0);
    read_lit(5'd4, 8'hFF, 8'hFF);

    // clr with a simultaneous read: read dropped, full clear follows
    wr(5'd9, 8'h3C, 1'b0);
    cycle(1'b1, 1'b0, 5'd9, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("lit_clr_ready", 0, 32'(ready_s[0]), 32'd0);
      chk("lit_clr_no_rvalid", 0, 32'(rvalid_s[0]), 32'd0);
      idle();
    end
    chk("lit_clr_done", 0, 32'(ready_s[0]), 32'd1);
    read_lit(5'd9, 8'h00, 8'h00);

    // Reset one cycle after a read accept flushes the latency-2 read
    rd(5'd5);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("lit_flush_rvalid", 1, 32'(rvalid_s[1]), 32'd0);
    for (int i = 0; i < DEPTH; i++) idle();
    chk("lit_ready_after_reset", 1, 32'(ready_s[1]), 32'd1);

    // Parity injection
    wr(5'd7, 8'h0F, 1'b1);
    wr(5'd8, 8'h0F, 1'b0);
    rd(5'd7);
    chk("lit_par_inj", 0, 32'(perr_s[0]), 32'(PAR_ON));
    rd(5'd8);
    chk("lit_par_ok", 0, 32'(perr_s[0]), 32'd0);
    idle();
    idle();

    // Randomised traffic with occasional clr and reset
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        reset = 1'b1;
        idle();
        reset = 1'b0;
      end else if (r < 10) begin
        cycle(1'($urandom_range(0, 1)), 1'b0, 5'($urandom_range(0, 31)), 8'h00, 1'b1, 1'b0);
      end else begin
        cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
              8'($urandom), 1'b0, ($urandom_range(0, 7) == 0));
      end
    end
    idle();
    idle();
    idle();
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/dmem_sync.md
Name: dmem_sync

Overview:
- Parametrised, synchronous-read data memory for the basic processor; successor to the current combinational-read data memory.
- Adds a registered read pipeline of configurable latency and a req/ready/rvalid handshake.
- Adds a hardware clear sequencer that zeroes every word after reset or on demand.
- Adds a write-protected low-address region with an error pulse.
- Sits between the processor datapath and the data-address space.

Parameters:
WORD_W, 8, data word width in bits
OP_W, 3, opcode field width; address width ADDR_W = WORD_W-OP_W; DEPTH = 2**ADDR_W
RD_LAT, 1, read latency in cycles from acceptance edge to rvalid; legal values 1 or 2
RO_LIMIT, 0, addresses strictly below RO_LIMIT are write-protected; 0 = no protection

Ports:
clock  in  1  single system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req  in  1  transfer request
we  in  1  1 = write, 0 = read; sampled only with req
addr  in  ADDR_W  word address
wdata  in  WORD_W  write data
clr  in  1  request a full memory clear; single-cycle pulse
par_inj  in  1  invert stored parity on this write (used only with DMEM_PARITY_EN)
ready  out  1  block accepts req this cycle
rvalid  out  1  one-cycle pulse, rdata valid
rdata  out  WORD_W  read data; holds last value between reads
wr_err  out  1  one-cycle pulse, a protected write was dropped
init_done  out  1  high once first clear has completed since reset
par_err  out  1  parity mismatch, qualified by rvalid

Behaviour:
- Reset (reset=1 at an edge):
  - state CLEAR, clear counter 0.
  - ready, rvalid, wr_err, init_done, par_err = 0; rdata = 0.
  - Read pipeline flushed; in-flight reads are lost and never return rvalid.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each edge writes 0 (with correct parity) to mem[cnt], then cnt++.
  - The edge that writes DEPTH-1 moves to IDLE; ready=1 from the next cycle.
  - First clear after reset: DEPTH edges with reset low, then ready=1 and init_done=1.
  - init_done stays 1 until the next reset.
- IDLE:
  - ready=1 continuously.
  - Accept = req && ready; one transfer per cycle, fully pipelined.
  - clr=1 in IDLE: go to CLEAR next edge with cnt=0 and ready=0; req in the same cycle is ignored.
  - clr while in CLEAR is ignored; the clear is not restarted.
- Write accept, addr >= RO_LIMIT: mem[addr] <= wdata at the acceptance edge.
- Write accept, addr < RO_LIMIT: memory unchanged; wr_err=1 for exactly the next cycle.
- Read accept:
  - Sample mem[addr] at the acceptance edge.
  - rvalid=1 and rdata updated RD_LAT cycles after that edge.
  - Back-to-back reads give back-to-back rvalid in order.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. No bypass is needed, because the write and read are in different cycles.
- Reads accepted before clr complete normally during CLEAR; their data is the pre-clear value.
- ready=0 during CLEAR; req is ignored and causes no side effects.
- Addresses wrap naturally within ADDR_W; there are no out-of-range addresses.
- wdata and we are don't-care when req=0.

Optional Feature:
DMEM_PARITY_EN:
- Defined:
  - Each word stores an extra even-parity bit, computed from wdata (inverted if par_inj=1).
  - On read, par_err = (recomputed parity != stored parity) and is presented with rvalid.
  - par_err = 0 whenever rvalid = 0.
  - The clear sequence writes correct parity.
- Undefined:
  - No parity storage.
  - par_err tied 0; par_inj ignored.

Test Plan:
- Reset 1 cycle, then idle -> ready=0 for 32 edges; ready=1 and init_done=1 after the 32nd edge (WORD_W=8, OP_W=3); reads of addresses 0, 17 and 31 return 8'h00.
- Write 8'hA5 @5, read @5 next cycle, RD_LAT=1 -> rvalid one cycle after the read edge with rdata=8'hA5. With RD_LAT=2 -> two cycles after.
- Reads @1,@2,@3 on consecutive cycles holding 8'h11, 8'h22, 8'h33 -> three consecutive rvalid pulses carrying 11, 22, 33 in order.
- RO_LIMIT=4: write 8'hFF @3 -> wr_err=1 for one cycle and read @3 returns 8'h00. Write 8'hFF @4 -> no wr_err and read @4 returns 8'hFF.
- Write 8'h3C @9, read @9 in the same cycle as clr=1 -> read not accepted; ready=0 for 32 cycles; afterwards read @9 returns 8'h00. Separately, reset asserted one cycle after a read accept (RD_LAT=2) -> no rvalid for that read.
- DMEM_PARITY_EN: write 8'h0F @7 with par_inj=1, read @7 -> rvalid with par_err=1. Write 8'h0F @8 with par_inj=0, read @8 -> par_err=0.
